// File: rtl/mp3_pkg.sv
// Shared MP3 data-path definitions: shifter states, byte width, divider counter sizing.
package mp3_pkg;

    localparam int unsigned MP3_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } mp3_state_e;

    // Width of a counter that runs DIV-1..0; never narrower than one bit.
    function automatic int unsigned div_cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/mp3_data_ser_if.sv
// Byte handshake between the mp3 DMA controller (master) and the serializer (slave).
interface mp3_data_ser_if;
    import mp3_pkg::*;

    logic [MP3_BITS-1:0] md_din;
    logic                md_start;
    logic                md_rdy;
    logic                md_dreq;
    logic                md_busy;

    modport master (
        output md_din,
        output md_start,
        input  md_rdy,
        input  md_dreq,
        input  md_busy
    );

    modport slave (
        input  md_din,
        input  md_start,
        output md_rdy,
        output md_dreq,
        output md_busy
    );
endinterface

// File: rtl/mp3_dreq_sync.sv
// Two-flop synchronizer bringing the decoder's DREQ into the clk domain.
module mp3_dreq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Shift the asynchronous input through two flops; both clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mp3_data_ser.sv
// MP3 SDI serializer: double-buffered byte in, MSB-first DCLK/SDATA/BSYNC out.
// Optional feature: define MP3_BSYNC_EN to drive mp3_sync high for bit 7 of each byte.
module mp3_data_ser
    import mp3_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mp3_data_ser_if.slave md,
    input  logic          mp3_dreq_in,
    output logic          mp3_clk,
    output logic          mp3_dat,
    output logic          mp3_sync
);
    localparam int unsigned DIV_W = div_cnt_width(DIV);
    localparam int unsigned BIT_W = $clog2(MP3_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MP3_BITS - 1);

    logic [MP3_BITS-1:0] hold;
    logic                hold_full;
    logic [MP3_BITS-1:0] shift;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DIV_W-1:0]    div_cnt;
    mp3_state_e          state;

    logic                accept_c;
    logic                phase_end_c;
    logic                last_high_c;
    logic                load_c;
    logic                hold_full_nxt;
    mp3_state_e          state_nxt;

    mp3_dreq_sync u_dreq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mp3_dreq_in),
        .q     (md.md_dreq)
    );

    // Next-state decode; a load can chain straight off the final HIGH phase.
    always_comb begin
        accept_c      = md.md_start && md.md_rdy;
        phase_end_c   = (div_cnt == '0);
        last_high_c   = (state == ST_HIGH) && phase_end_c && (bit_cnt == '0);
        load_c        = hold_full && ((state == ST_IDLE) || last_high_c);
        hold_full_nxt = hold_full;
        state_nxt     = state;
        if (accept_c) begin
            hold_full_nxt = 1'b1;
        end else if (load_c) begin
            hold_full_nxt = 1'b0;
        end
        unique case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_LOW:  if (phase_end_c) state_nxt = ST_HIGH;
            ST_HIGH: if (phase_end_c) state_nxt = (bit_cnt == '0) ? ST_IDLE : ST_LOW;
            default: state_nxt = ST_IDLE;
        endcase
        if (load_c) begin
            state_nxt = ST_LOW;
        end
    end

    // Holding register, shifter, counters and registered handshake/serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            mp3_clk    <= 1'b0;
            mp3_dat    <= 1'b0;
            md.md_rdy  <= 1'b1;
            md.md_busy <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_full  <= hold_full_nxt;
            md.md_rdy  <= !hold_full_nxt;
            md.md_busy <= hold_full_nxt || (state_nxt != ST_IDLE);
            if (accept_c) begin
                hold <= md.md_din;
            end
            if (load_c) begin
                shift   <= hold;
                bit_cnt <= BIT_LAST;
                div_cnt <= DIV_LAST;
                mp3_clk <= 1'b0;
                mp3_dat <= hold[MP3_BITS-1];
            end else if (state != ST_IDLE) begin
                if (!phase_end_c) begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end else begin
                    div_cnt <= DIV_LAST;
                    if (state == ST_LOW) begin
                        mp3_clk <= 1'b1;
                    end else begin
                        mp3_clk <= 1'b0;
                        if (bit_cnt != '0) begin
                            shift   <= shift << 1;
                            bit_cnt <= bit_cnt - BIT_W'(1);
                            mp3_dat <= shift[MP3_BITS-2];
                        end
                    end
                end
            end
        end
    end

`ifdef MP3_BSYNC_EN
    // BSYNC covers both phases of the first (MSB) bit of every byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp3_sync <= 1'b0;
        end else if (load_c) begin
            mp3_sync <= 1'b1;
        end else if ((state == ST_HIGH) && phase_end_c) begin
            mp3_sync <= 1'b0;
        end
    end
`else
    assign mp3_sync = 1'b0;
`endif

endmodule
